// File: rtl/uart_rx.sv
// UART receiver, 8N1, oversampled by a programmable baud divisor, feeding a
// circular byte queue with first-word-fall-through read and sticky error flags.
module uart_rx #(
    parameter int ADDR_W = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] baud_div_i,
    input  logic        rx_i,
    input  logic        re_i,
    input  logic        clr_err_i,
    output logic [7:0]  data_o,
    output logic        empty_o,
    output logic        full_o,
    output logic        overrun_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                  state_reg;
    logic [15:0]             cnt_reg;
    logic [2:0]              bit_idx_reg;
    logic [7:0]              shift_reg;
    logic [ADDR_W-1:0]       rd_ptr_reg;
    logic [ADDR_W-1:0]       wr_ptr_reg;
    logic                    overrun_reg;
    logic                    frame_err_reg;
    logic [SYNC_STAGES-1:0]  sync_reg;
    logic [7:0]              mem [DEPTH];

    logic        rx_s;
    logic [15:0] half_div;
    logic        bit_end;
    logic        push;
    logic        pop;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_next;

    // Two-flop synchronizer on the asynchronous serial line, idle-high on reset.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    sync_reg[gi] <= rx_i;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign rx_s     = sync_reg[SYNC_STAGES-1];
    assign half_div = {1'b0, baud_div_i[15:1]};
    assign bit_end  = (cnt_reg == baud_div_i);

    assign wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
    assign rd_ptr_next = rd_ptr_reg + ADDR_W'(1);

    assign empty_o = (rd_ptr_reg == wr_ptr_reg);
    assign full_o  = (wr_ptr_next == rd_ptr_reg);

    // Full is judged on the pre-pop pointers, so a push into a full queue drops
    // even when a pop happens in the same cycle.
    assign push = (state_reg == STOP) && bit_end && rx_s && !full_o;
    assign pop  = re_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    assign data_o = mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_next;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            if (clr_err_i) begin
                overrun_reg   <= 1'b0;
                frame_err_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (!rx_s) begin
                        state_reg <= START;
                    end
                end
                START: begin
                    if (cnt_reg == half_div) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            // Leaving at mid-stop-bit lets a following start bit be caught.
                            state_reg <= IDLE;
                            if (full_o) begin
                                overrun_reg <= 1'b1;
                            end
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= BREAK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                BREAK: begin
                    cnt_reg <= '0;
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign overrun_o   = overrun_reg;
    assign frame_err_o = frame_err_reg;
    assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at baud_div=4 (5 clocks per bit), driving the
// pin and sampling outputs on the falling clock edge.
module tb_uart_rx;

    localparam int T = 5;

    logic        clk_i;
    logic        rst_ni;
    logic [15:0] baud_div_i;
    logic        rx_i;
    logic        re_i;
    logic        clr_err_i;
    logic [7:0]  data_o;
    logic        empty_o;
    logic        full_o;
    logic        overrun_o;
    logic        frame_err_o;
    logic        busy_o;

    int n_cmp;
    int n_err;

    uart_rx #(.ADDR_W(5)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .baud_div_i  (baud_div_i),
        .rx_i        (rx_i),
        .re_i        (re_i),
        .clr_err_i   (clr_err_i),
        .data_o      (data_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        wait_cyc(T);
    endtask

    // Leaves the line at the stop-bit level; caller decides what follows.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic read_expect(input string tag, input logic [7:0] exp);
        check({tag, "_nempty"}, {31'd0, empty_o}, 32'd0);
        check(tag, {24'd0, data_o}, {24'd0, exp});
        re_i = 1'b1;
        wait_cyc(1);
        re_i = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic ovr, input logic ferr);
        check({tag, "_ovr"}, {31'd0, overrun_o}, {31'd0, ovr});
        check({tag, "_ferr"}, {31'd0, frame_err_o}, {31'd0, ferr});
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        baud_div_i = 16'd4;
        rx_i       = 1'b1;
        re_i       = 1'b0;
        clr_err_i  = 1'b0;
        rst_ni     = 1'b0;
        wait_cyc(3);

        check("rst_empty", {31'd0, empty_o}, 32'd1);
        check("rst_full", {31'd0, full_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check_flags("rst", 1'b0, 1'b0);
        rst_ni = 1'b1;
        wait_cyc(2);

        // Single frame
        send_frame(8'h55, 1'b1);
        rx_i = 1'b1;
        wait_cyc(2);
        check("t1_busy", {31'd0, busy_o}, 32'd0);
        check_flags("t1", 1'b0, 1'b0);
        read_expect("t1_data", 8'h55);
        check("t1_empty", {31'd0, empty_o}, 32'd1);

        // Back-to-back frames
        send_frame(8'hA5, 1'b1);
        check("t2_busy_mid", {31'd0, busy_o}, 32'd1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        rx_i = 1'b1;
        wait_cyc(2);
        check("t2_busy_end", {31'd0, busy_o}, 32'd0);
        read_expect("t2_d0", 8'hA5);
        read_expect("t2_d1", 8'h3C);
        read_expect("t2_d2", 8'hFF);
        check("t2_empty", {31'd0, empty_o}, 32'd1);

        // One-cycle glitch
        rx_i = 1'b0;
        wait_cyc(1);
        rx_i = 1'b1;
        wait_cyc(3);
        check("t3_busy_start", {31'd0, busy_o}, 32'd1);
        wait_cyc(4);
        check("t3_busy", {31'd0, busy_o}, 32'd0);
        check("t3_empty", {31'd0, empty_o}, 32'd1);
        check_flags("t3", 1'b0, 1'b0);

        // Framing error then held-low line
        send_frame(8'h81, 1'b0);
        wait_cyc(3 * T);
        check("t4_ferr_busy", {31'd0, busy_o}, 32'd1);
        check("t4_empty", {31'd0, empty_o}, 32'd1);
        check_flags("t4", 1'b0, 1'b1);
        rx_i = 1'b1;
        wait_cyc(4);
        check("t4_busy_idle", {31'd0, busy_o}, 32'd0);
        clr_err_i = 1'b1;
        wait_cyc(1);
        clr_err_i = 1'b0;
        check_flags("t4_clr", 1'b0, 1'b0);

        // Fill the queue past capacity; pointers start at 4 so this wraps
        for (int i = 0; i < 32; i++) begin
            send_frame(8'(i), 1'b1);
            rx_i = 1'b1;
            wait_cyc(2);
            if (i == 29) check("t5_full30", {31'd0, full_o}, 32'd0);
            if (i == 30) begin
                check("t5_full31", {31'd0, full_o}, 32'd1);
                check("t5_ovr31", {31'd0, overrun_o}, 32'd0);
            end
        end
        check("t5_full32", {31'd0, full_o}, 32'd1);
        check_flags("t5", 1'b1, 1'b0);
        for (int i = 0; i < 31; i++) begin
            read_expect($sformatf("t5_rd%0d", i), 8'(i));
        end
        check("t5_empty", {31'd0, empty_o}, 32'd1);

        // Reset mid-frame; overrun still set and one byte queued beforehand
        send_frame(8'h11, 1'b1);
        rx_i = 1'b1;
        wait_cyc(2);
        check("t6_pre_nempty", {31'd0, empty_o}, 32'd0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_i = 1'b0;
        wait_cyc(2);
        check("t6_pre_busy", {31'd0, busy_o}, 32'd1);
        rx_i   = 1'b1;
        rst_ni = 1'b0;
        wait_cyc(1);
        check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t6_rst_empty", {31'd0, empty_o}, 32'd1);
        check("t6_rst_full", {31'd0, full_o}, 32'd0);
        check_flags("t6_rst", 1'b0, 1'b0);
        rst_ni = 1'b1;
        wait_cyc(2);
        send_frame(8'h7E, 1'b1);
        rx_i = 1'b1;
        wait_cyc(2);
        read_expect("t6_data", 8'h7E);
        check("t6_empty", {31'd0, empty_o}, 32'd1);
        check_flags("t6_end", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver paired with the uart_tx block. It takes the same baud divisor, so one bit period is baud_div_i+1 clock cycles. Frame format is 1 start bit, 8 data bits LSB first, no parity, 1 stop bit. Received bytes go into a 32-slot circular queue that the bus-side peripheral wrapper reads; sticky overrun and framing-error flags report lost or bad frames.

Parameters:
ADDR_W, 5, queue pointer width; queue has 2^ADDR_W slots, usable capacity 2^ADDR_W-1 (one slot always empty).

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, synchronous, active-low
baud_div_i  input  16  bit period minus one, in clk_i cycles; must be >= 3; held constant while receiving
rx_i  input  1  serial line, asynchronous, idle high
re_i  input  1  pop head of queue this cycle; ignored when empty_o=1
clr_err_i  input  1  clear overrun_o and frame_err_o
data_o  output  8  head of queue (first-word-fall-through); valid only when empty_o=0
empty_o  output  1  queue empty
full_o  output  1  queue holds 2^ADDR_W-1 bytes
overrun_o  output  1  sticky: a good frame was dropped because the queue was full
frame_err_o  output  1  sticky: stop bit sampled low
busy_o  output  1  state != IDLE

Behaviour:
- Reset (rst_ni=0 at posedge): state=IDLE; read_ptr=write_ptr=0; counter=0; synchronizer flops=1; overrun_o=0, frame_err_o=0, empty_o=1, full_o=0, busy_o=0. Queue contents are not reset, so data_o is don't-care. Reset mid-frame aborts the frame with no push.
- rx_i passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. Latency from pin to rx_s is 2 cycles.
- Let T = baud_div_i+1 and H = baud_div_i>>1. Counter is 16 bits.
- IDLE: when rx_s==0, go to START and clear counter.
- START: counter increments each cycle. When counter==H, sample rx_s:
  - 0 → go to DATA, bit_idx=0, counter cleared.
  - 1 → glitch; return to IDLE with no flag.
- DATA: when counter==baud_div_i, shift rx_s into shift register MSB (LSB-first reception) and clear counter. After bit_idx 7 is sampled, go to STOP; otherwise increment bit_idx.
- STOP: when counter==baud_div_i, sample rx_s.
  - 1 and queue not full → push shift register at write_ptr, write_ptr+1, go to IDLE.
  - 1 and full → drop byte, set overrun_o, go to IDLE.
  - 0 → drop byte, set frame_err_o, go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE (prevents re-triggering on a held-low line).
- Sampling is mid-bit. Returning to IDLE at mid-stop-bit allows back-to-back frames with no gap.
- Queue:
  - empty_o = (read_ptr==write_ptr).
  - full_o = (write_ptr+1 == read_ptr), mod 2^ADDR_W.
  - data_o = queue[read_ptr], combinational.
  - re_i with empty_o=0 advances read_ptr.
  - Pointers wrap modulo 2^ADDR_W.
- Simultaneous events:
  - Push and pop in the same cycle: both occur, and the count is unchanged.
  - Push when full_o=1 and re_i=1 in the same cycle: full is evaluated before the pop, so the byte is dropped and overrun_o is set.
  - clr_err_i and a flag set in the same cycle: set wins.
- Latency: the byte is visible on data_o, with empty_o=0, the cycle after the STOP sample edge.

Test Plan:
1. baud_div_i=4 (T=5): drive frame 0x55 at pin → after the stop sample, empty_o=0, data_o=0x55, flags 0. Pulse re_i → empty_o=1.
2. Back-to-back frames 0xA5, 0x3C, 0xFF with no idle gap → queue yields A5, 3C, FF in order; busy_o=0 only between frames.
3. rx_i low for 1 cycle (glitch, < H) → no push, no flag, state returns to IDLE.
4. Frame 0x81 with stop bit driven 0, then line held low for 3T → frame_err_o=1, empty_o=1, no new frame starts until the line goes high. clr_err_i → frame_err_o=0.
5. Send 32 frames 0x00..0x1F without reading → full_o after 31 bytes; the 32nd sets overrun_o. Reads return 0x00..0x1E, then empty_o=1 (exercises pointer wrap).
6. Assert rst_ni=0 during DATA bit 4 → next cycle all outputs at reset values. The following clean frame 0x7E is received correctly.
